// File: rtl/in_byte_pkg.sv
// Shared constants and decode helper for the in_byte_port bus responder.
package in_byte_pkg;

    localparam logic [31:0] DEFAULT_DATA_ADDR   = 32'h1000_0004;
    localparam logic [31:0] DEFAULT_STATUS_ADDR = 32'h1000_0008;

    // Status register bit positions
    localparam int ST_NEMPTY    = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_COUNT_LSB = 8;

    // Returned by a DATA read on an empty FIFO; distinguishable from any byte
    localparam logic [31:0] EMPTY_READ_VALUE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        REG_NONE   = 2'd0,
        REG_DATA   = 2'd1,
        REG_STATUS = 2'd2
    } reg_sel_e;

    // Exact word-address match; anything else (including misaligned) is not ours
    function automatic reg_sel_e decode_addr(input logic [31:0] addr,
                                             input logic [31:0] data_addr,
                                             input logic [31:0] status_addr);
        if (addr == data_addr)
            return REG_DATA;
        else if (addr == status_addr)
            return REG_STATUS;
        else
            return REG_NONE;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide FIFO with synchronous flush; push/pop are ignored when full/empty.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    // Flush wins over everything, so a byte arriving on a flush edge is dropped
    assign w_push = push && !full  && !flush;
    assign w_pop  = pop  && !empty && !flush;

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage has no reset; contents are meaningless once the pointers are cleared
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/in_byte_port.sv
// picorv32 native-bus responder: CPU polls STATUS and pops bytes from DATA.
module in_byte_port
    import in_byte_pkg::*;
#(
    parameter int          DEPTH       = 8,
    parameter logic [31:0] DATA_ADDR   = DEFAULT_DATA_ADDR,
    parameter logic [31:0] STATUS_ADDR = DEFAULT_STATUS_ADDR
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        hit,
    input  logic [7:0]  in_byte,
    input  logic        in_byte_valid,
    output logic        in_byte_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          r_ready;
    logic [31:0]   r_rdata;
    reg_sel_e      w_sel;
    logic          w_req;
    logic          w_read;
    logic          w_pop;
    logic          w_flush;
    logic          w_full;
    logic          w_empty;
    logic [7:0]    w_dout;
    logic [CW-1:0] w_count;
    logic [31:0]   w_status;
    logic [31:0]   w_rdata_nxt;
    logic          w_unused_wdata;

    assign w_sel = decode_addr(mem_addr, DATA_ADDR, STATUS_ADDR);
    assign hit   = mem_valid && (w_sel != REG_NONE);

    // A request is taken only while not already acknowledging, so a held
    // mem_valid gets exactly one response per ready pulse
    assign w_req   = hit && !r_ready;
    assign w_read  = (mem_wstrb == 4'b0000);
    assign w_pop   = w_req && w_read && (w_sel == REG_DATA);
    assign w_flush = w_req && !w_read && (w_sel == REG_STATUS)
                     && mem_wstrb[0] && mem_wdata[0];

    // Only the flush bit of the write data carries meaning
    assign w_unused_wdata = ^mem_wdata[31:1];

    assign in_byte_ready = !w_full;
    assign mem_ready     = r_ready;
    assign mem_rdata     = r_rdata;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (resetn),
        .push  (in_byte_valid),
        .pop   (w_pop),
        .flush (w_flush),
        .din   (in_byte),
        .dout  (w_dout),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // Status word built from the pre-edge FIFO state
    always_comb begin
        w_status                       = '0;
        w_status[ST_NEMPTY]            = !w_empty;
        w_status[ST_FULL]              = w_full;
        w_status[ST_COUNT_LSB +: CW]   = w_count;
    end

    // Read mux; writes return zero data
    always_comb begin
        w_rdata_nxt = '0;
        if (w_read) begin
            case (w_sel)
                REG_DATA:   w_rdata_nxt = w_empty ? EMPTY_READ_VALUE : {24'b0, w_dout};
                REG_STATUS: w_rdata_nxt = w_status;
                default:    w_rdata_nxt = '0;
            endcase
        end
    end

    // One-cycle acknowledge pulse; rdata is zero whenever ready is low so the
    // system can OR this block with memory
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_req;
            r_rdata <= w_req ? w_rdata_nxt : '0;
        end
    end

endmodule

// File: tb/tb_in_byte_port.sv
// Self-checking bench for in_byte_port: vector table, corner sequences, random vs queue model.
module tb_in_byte_port;

    localparam int          DEPTH = 8;
    localparam logic [31:0] DA    = 32'h1000_0004;
    localparam logic [31:0] SA    = 32'h1000_0008;
    localparam logic [31:0] OA    = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        hit;
    logic [7:0]  in_byte = '0;
    logic        in_byte_valid = 1'b0;
    logic        in_byte_ready;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] q[$];

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        pv;
        logic [7:0]  pb;
        logic        chk_rd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    in_byte_port #(.DEPTH(DEPTH), .DATA_ADDR(DA), .STATUS_ADDR(SA)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .mem_valid     (mem_valid),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .hit           (hit),
        .in_byte       (in_byte),
        .in_byte_valid (in_byte_valid),
        .in_byte_ready (in_byte_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Status as the rules define it, from an occupancy count
    function automatic logic [31:0] status_of(input int n);
        logic [31:0] s;
        s = 32'(n) * 32'd256;
        if (n != 0)     s = s + 32'd1;
        if (n == DEPTH) s = s + 32'd2;
        return s;
    endfunction

    function automatic vec_t mk(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                                input logic pv, input logic [7:0] pb, input logic cr, input logic [31:0] e);
        vec_t v;
        v.addr = a; v.wstrb = ws; v.wdata = wd; v.pv = pv; v.pb = pb; v.chk_rd = cr; v.exp = e;
        return v;
    endfunction

    // Entered and left at a negedge; one acknowledged access followed by one idle cycle
    task automatic bus(input logic [31:0] addr, input logic [3:0] ws, input logic [31:0] wd,
                       input logic pv, input logic [7:0] pb,
                       output logic [31:0] rd, output logic rdy);
        mem_valid = 1'b1; mem_addr = addr; mem_wstrb = ws; mem_wdata = wd;
        in_byte_valid = pv; in_byte = pb;
        @(posedge clk); @(negedge clk);
        rd = mem_rdata; rdy = mem_ready;
        mem_valid = 1'b0; mem_wstrb = '0; mem_wdata = '0; in_byte_valid = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic push_cyc(input logic pv, input logic [7:0] pb);
        in_byte_valid = pv; in_byte = pb;
        @(posedge clk); @(negedge clk);
        in_byte_valid = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        rdy;
        bus(addr, 4'h0, 32'h0, 1'b0, 8'h00, rd, rdy);
        chk({name, "_ready"}, {31'b0, rdy}, 32'd1);
        chk(name, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;
        logic        rdy;
        int          op;
        int          n;
        logic        pv;
        logic [7:0]  pb;
        logic        fl;
        logic [31:0] exp;
        logic [3:0]  ws;

        // ---------------- reset ----------------
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, mem_ready}, 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        chk("rst_in_ready", {31'b0, in_byte_ready}, 32'd1);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_hit", {31'b0, hit}, 32'd0);

        // ---------------- vector table ----------------
        tbl.push_back(mk(SA, 4'h0, 32'h0,  1'b1, 8'hA5, 1'b1, 32'h0000_0000));
        tbl.push_back(mk(SA, 4'h0, 32'h0,  1'b1, 8'h3C, 1'b1, 32'h0000_0101));
        tbl.push_back(mk(SA, 4'h0, 32'h0,  1'b0, 8'h00, 1'b1, 32'h0000_0201));
        tbl.push_back(mk(DA, 4'h0, 32'h0,  1'b0, 8'h00, 1'b1, 32'h0000_00A5));
        tbl.push_back(mk(DA, 4'h0, 32'h0,  1'b0, 8'h00, 1'b1, 32'h0000_003C));
        tbl.push_back(mk(SA, 4'h0, 32'h0,  1'b0, 8'h00, 1'b1, 32'h0000_0000));
        tbl.push_back(mk(DA, 4'h0, 32'h0,  1'b0, 8'h00, 1'b1, 32'hFFFF_FFFF));
        tbl.push_back(mk(SA, 4'h0, 32'h0,  1'b0, 8'h00, 1'b1, 32'h0000_0000));
        tbl.push_back(mk(DA, 4'hF, 32'h55, 1'b1, 8'h11, 1'b0, 32'h0));
        tbl.push_back(mk(SA, 4'h0, 32'h0,  1'b0, 8'h00, 1'b1, 32'h0000_0101));
        tbl.push_back(mk(SA, 4'h1, 32'h1,  1'b1, 8'h22, 1'b0, 32'h0));
        tbl.push_back(mk(SA, 4'h0, 32'h0,  1'b0, 8'h00, 1'b1, 32'h0000_0000));
        tbl.push_back(mk(SA, 4'h1, 32'h0,  1'b1, 8'h33, 1'b0, 32'h0));
        tbl.push_back(mk(SA, 4'h2, 32'h1,  1'b0, 8'h00, 1'b0, 32'h0));
        tbl.push_back(mk(SA, 4'h0, 32'h0,  1'b0, 8'h00, 1'b1, 32'h0000_0101));
        tbl.push_back(mk(DA, 4'h0, 32'h0,  1'b0, 8'h00, 1'b1, 32'h0000_0033));
        for (int i = 0; i < tbl.size(); i++) begin
            bus(tbl[i].addr, tbl[i].wstrb, tbl[i].wdata, tbl[i].pv, tbl[i].pb, rd, rdy);
            chk($sformatf("vec%0d_ready", i), {31'b0, rdy}, 32'd1);
            if (tbl[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp);
        end

        // ---------------- held mem_valid on empty DATA ----------------
        mem_valid = 1'b1; mem_addr = DA; mem_wstrb = 4'h0;
        #1;
        chk("hold_hit", {31'b0, hit}, 32'd1);
        chk("hold_c1_ready", {31'b0, mem_ready}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("hold_c2_ready", {31'b0, mem_ready}, 32'd1);
        chk("hold_c2_rdata", mem_rdata, 32'hFFFF_FFFF);
        @(posedge clk); @(negedge clk);
        chk("hold_c3_ready", {31'b0, mem_ready}, 32'd0);
        chk("hold_c3_rdata", mem_rdata, 32'd0);
        mem_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        read_chk("hold_status", SA, 32'h0);

        // ---------------- fill to full, stalled ninth push ----------------
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("fill%0d_in_ready", i), {31'b0, in_byte_ready}, 32'd1);
            push_cyc(1'b1, 8'(i));
        end
        chk("full_in_ready", {31'b0, in_byte_ready}, 32'd0);
        read_chk("full_status", SA, status_of(DEPTH));
        mem_valid = 1'b1; mem_addr = DA; mem_wstrb = 4'h0;
        in_byte_valid = 1'b1; in_byte = 8'h08;
        @(posedge clk); @(negedge clk);
        chk("stall_pop_ready", {31'b0, mem_ready}, 32'd1);
        chk("stall_pop_rdata", mem_rdata, 32'h0000_0000);
        mem_valid = 1'b0;
        chk("stall_in_ready", {31'b0, in_byte_ready}, 32'd1);
        @(posedge clk); @(negedge clk);
        in_byte_valid = 1'b0;
        chk("ninth_in_ready", {31'b0, in_byte_ready}, 32'd0);
        for (int i = 1; i <= DEPTH; i++)
            read_chk($sformatf("drain%0d", i), DA, 32'(i));
        read_chk("drain_status", SA, 32'h0);

        // ---------------- simultaneous push and pop at count 3 ----------------
        push_cyc(1'b1, 8'h41);
        push_cyc(1'b1, 8'h42);
        push_cyc(1'b1, 8'h43);
        bus(DA, 4'h0, 32'h0, 1'b1, 8'h44, rd, rdy);
        chk("pp_ready", {31'b0, rdy}, 32'd1);
        chk("pp_rdata", rd, 32'h41);
        read_chk("pp_status", SA, 32'h0000_0301);
        read_chk("pp_r1", DA, 32'h42);
        read_chk("pp_r2", DA, 32'h43);
        read_chk("pp_r3", DA, 32'h44);

        // ---------------- foreign and misaligned addresses ----------------
        push_cyc(1'b1, 8'h77);
        mem_valid = 1'b1; mem_addr = OA; mem_wstrb = 4'h0;
        #1;
        chk("oa_hit", {31'b0, hit}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("oa_ready", {31'b0, mem_ready}, 32'd0);
        chk("oa_rdata", mem_rdata, 32'd0);
        mem_addr = DA + 32'd1;
        #1;
        chk("mis_hit", {31'b0, hit}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("mis_ready", {31'b0, mem_ready}, 32'd0);
        mem_valid = 1'b0;
        read_chk("oa_status", SA, 32'h0000_0101);
        read_chk("oa_data", DA, 32'h77);

        // ---------------- random traffic against a queue model ----------------
        q.delete();
        for (int it = 0; it < 300; it++) begin
            op = int'($urandom_range(0, 5));
            pv = ($urandom_range(0, 2) != 0);
            pb = 8'($urandom);
            n  = q.size();
            fl = 1'b0;
            chk($sformatf("rnd%0d_in_ready", it), {31'b0, in_byte_ready}, {31'b0, n < DEPTH});
            case (op)
                0, 1: begin
                    bus(DA, 4'h0, 32'h0, pv, pb, rd, rdy);
                    exp = (n != 0) ? {24'b0, q[0]} : 32'hFFFF_FFFF;
                    if (n != 0) void'(q.pop_front());
                    chk($sformatf("rnd%0d_data", it), rd, exp);
                end
                2: begin
                    bus(SA, 4'h0, 32'h0, pv, pb, rd, rdy);
                    chk($sformatf("rnd%0d_status", it), rd, status_of(n));
                end
                3: begin
                    bus(SA, 4'h1, {$urandom} | 32'h1, pv, pb, rd, rdy);
                    fl = 1'b1;
                    q.delete();
                end
                4: begin
                    ws = 4'($urandom_range(1, 15));
                    bus(DA, ws, $urandom, pv, pb, rd, rdy);
                end
                default: begin
                    push_cyc(pv, pb);
                    rdy = 1'b1;
                end
            endcase
            chk($sformatf("rnd%0d_ready", it), {31'b0, rdy}, 32'd1);
            if (pv && !fl && n < DEPTH) q.push_back(pb);
        end

        // ---------------- reset mid-request ----------------
        push_cyc(1'b1, 8'h55);
        push_cyc(1'b1, 8'h66);
        mem_valid = 1'b1; mem_addr = DA; mem_wstrb = 4'h0;
        @(posedge clk);
        #2;
        chk("mid_ready_before", {31'b0, mem_ready}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid_ready_async", {31'b0, mem_ready}, 32'd0);
        chk("mid_rdata_async", mem_rdata, 32'd0);
        chk("mid_in_ready", {31'b0, in_byte_ready}, 32'd1);
        mem_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        read_chk("mid_status", SA, 32'h0);
        read_chk("mid_data", DA, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
